// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sequencer state encoding and complex sample type.
package fft_pkg;
   localparam int DATA_W = 16;
   localparam int N_PTS = 8;
   typedef enum logic [2:0] {LOAD, WRITE, START, WAIT, CAPTURE, DRAIN} state_t;
   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: complex register file with indexed write/read, parallel load and flat-bus view.
module fft_frame_buf #(
   parameter int W = 16,
   parameter int N = 8,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic [W-1:0]  wr_re,
   input  logic [W-1:0]  wr_im,
   input  logic          ld_en,
   input  logic [N*W-1:0] ld_re,
   input  logic [N*W-1:0] ld_im,
   input  logic [IW-1:0] rd_idx,
   output logic [W-1:0]  rd_re,
   output logic [W-1:0]  rd_im,
   output logic [N*W-1:0] flat_re,
   output logic [N*W-1:0] flat_im
);
   logic [W-1:0] re_q [N];
   logic [W-1:0] im_q [N];
   always_ff @(posedge clk)
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            re_q[k] <= '0;
            im_q[k] <= '0;
         end
      end else if (ld_en) begin
         for (int k = 0; k < N; k++) begin
            re_q[k] <= ld_re[k*W +: W];
            im_q[k] <= ld_im[k*W +: W];
         end
      end else if (wr_en) begin
         re_q[wr_idx] <= wr_re;
         im_q[wr_idx] <= wr_im;
      end
   for (genvar i = 0; i < N; i++) begin : g_flat
      assign flat_re[i*W +: W] = re_q[i];
      assign flat_im[i*W +: W] = im_q[i];
   end
   assign rd_re = re_q[rd_idx];
   assign rd_im = im_q[rd_idx];
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: collects a sample frame, sequences the FFT datapath and streams out the bins.
module fft_frame_sequencer #(
   parameter int DATA_W = 16,
   parameter int N_PTS = 8,
   parameter int FFT_LAT = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_W-1:0]       s_real,
   input  logic [DATA_W-1:0]       s_imag,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_W-1:0]       m_real,
   output logic [DATA_W-1:0]       m_imag,
   output logic [2:0]              m_index,
   output logic                    m_last,
   output logic                    fft_write,
   output logic                    fft_start,
   output logic [N_PTS*DATA_W-1:0] fft_in_real,
   output logic [N_PTS*DATA_W-1:0] fft_in_imag,
   input  logic [N_PTS*DATA_W-1:0] fft_out_real,
   input  logic [N_PTS*DATA_W-1:0] fft_out_imag,
   output logic                    busy,
   output logic                    frame_err,
   output logic [15:0]             frames_done
);
   import fft_pkg::*;
   state_t state;
   logic [2:0] cnt;
   logic [2:0] bin;
   logic [3:0] wcnt;
   logic take;
   logic bad_last;
   logic [DATA_W-1:0] in_rd_re_unused;
   logic [DATA_W-1:0] in_rd_im_unused;
   logic [N_PTS*DATA_W-1:0] res_flat_re_unused;
   logic [N_PTS*DATA_W-1:0] res_flat_im_unused;
   assign take = s_valid && s_ready;
   assign bad_last = s_last && cnt != 3'd7;
   assign m_index = bin;
   // a premature s_last never reaches the buffer; its slot is rewritten by the restarted frame
   fft_frame_buf #(.W(DATA_W), .N(N_PTS)) u_in_buf (
      .clk(clk), .rst(rst),
      .wr_en(take && !bad_last), .wr_idx(cnt), .wr_re(s_real), .wr_im(s_imag),
      .ld_en(1'b0), .ld_re('0), .ld_im('0),
      .rd_idx(3'd0), .rd_re(in_rd_re_unused), .rd_im(in_rd_im_unused),
      .flat_re(fft_in_real), .flat_im(fft_in_imag)
   );
   fft_frame_buf #(.W(DATA_W), .N(N_PTS)) u_res_buf (
      .clk(clk), .rst(rst),
      .wr_en(1'b0), .wr_idx(3'd0), .wr_re('0), .wr_im('0),
      .ld_en(state == CAPTURE), .ld_re(fft_out_real), .ld_im(fft_out_imag),
      .rd_idx(bin), .rd_re(m_real), .rd_im(m_imag),
      .flat_re(res_flat_re_unused), .flat_im(res_flat_im_unused)
   );
   // outputs are set from the next state so they change on the same edge as the state
   always_ff @(posedge clk)
      if (!rst) begin
         state <= LOAD;
         cnt <= '0;
         bin <= '0;
         wcnt <= '0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_last <= 1'b0;
         fft_write <= 1'b0;
         fft_start <= 1'b0;
         busy <= 1'b0;
         frame_err <= 1'b0;
         frames_done <= '0;
      end else begin
         fft_write <= 1'b0;
         fft_start <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            LOAD: begin
               s_ready <= 1'b1;
               if (take) begin
                  if (bad_last) begin
                     frame_err <= 1'b1;
                     cnt <= '0;
                  end else if (cnt == 3'd7) begin
                     frame_err <= !s_last;
                     cnt <= '0;
                     state <= WRITE;
                     s_ready <= 1'b0;
                     busy <= 1'b1;
                     fft_write <= 1'b1;
                  end else cnt <= cnt + 3'd1;
               end
            end
            WRITE: begin
               state <= START;
               fft_start <= 1'b1;
            end
            START: begin
               state <= WAIT;
               wcnt <= 4'(FFT_LAT - 1);
            end
            WAIT: begin
               if (wcnt == '0) state <= CAPTURE;
               else wcnt <= wcnt - 4'd1;
            end
            CAPTURE: begin
               state <= DRAIN;
               bin <= '0;
               m_valid <= 1'b1;
               m_last <= 1'b0;
            end
            DRAIN: begin
               if (m_ready) begin
                  if (bin == 3'd7) begin
                     state <= LOAD;
                     bin <= '0;
                     m_valid <= 1'b0;
                     m_last <= 1'b0;
                     s_ready <= 1'b1;
                     busy <= 1'b0;
                     frames_done <= frames_done + 16'd1;
                  end else begin
                     bin <= bin + 3'd1;
                     m_last <= bin == 3'd6;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed tests of the frame sequencer against a stub / behavioural FFT datapath.
module tb_fft_frame_sequencer;
   localparam int W = 16;
   localparam int LAT = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s_valid = 1'b0, s_ready, s_last = 1'b0;
   logic [W-1:0] s_real = '0, s_imag = '0;
   logic m_valid, m_ready = 1'b0, m_last;
   logic [W-1:0] m_real, m_imag;
   logic [2:0] m_index;
   logic fft_write, fft_start, busy, frame_err;
   logic [15:0] frames_done;
   logic [8*W-1:0] fft_in_real, fft_in_imag;
   logic [8*W-1:0] fft_out_real = '0, fft_out_imag = '0;
   logic [8*W-1:0] pend_re = '0, pend_im = '0;
   int pend = 0;
   bit real_mode = 1'b0;
   int checks = 0, errors = 0;
   int cyc = 0, wr_cnt = 0, st_cnt = 0, both_cnt = 0, ferr_cnt = 0, nrise = 0;
   int rise_cyc [8];
   logic mv_prev = 1'b0;
   logic signed [W-1:0] in_re [8], in_im [8];
   logic [W-1:0] obs_re [8], obs_im [8];
   logic [2:0] obs_idx [8];
   logic obs_last [8];
   int stab_bad = 0, sready_bad = 0;

   always #5 clk = ~clk;

   fft_frame_sequencer #(.DATA_W(W), .N_PTS(8), .FFT_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
      .m_index(m_index), .m_last(m_last),
      .fft_write(fft_write), .fft_start(fft_start),
      .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
      .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
      .busy(busy), .frame_err(frame_err), .frames_done(frames_done)
   );

   // datapath model: identity stub or a rounded 8-point DFT, valid LAT cycles after fft_start
   always @(posedge clk) begin : datapath
      real ar, ai, xr, xi, ang;
      if (fft_start) begin
         pend <= LAT;
         for (int k = 0; k < 8; k++) begin
            if (!real_mode) begin
               pend_re[k*W +: W] <= fft_in_real[k*W +: W];
               pend_im[k*W +: W] <= fft_in_imag[k*W +: W];
            end else begin
               ar = 0.0;
               ai = 0.0;
               for (int n = 0; n < 8; n++) begin
                  xr = $itor($signed(fft_in_real[n*W +: W]));
                  xi = $itor($signed(fft_in_imag[n*W +: W]));
                  ang = 2.0 * 3.14159265358979 * n * k / 8.0;
                  ar = ar + xr * $cos(ang) + xi * $sin(ang);
                  ai = ai + xi * $cos(ang) - xr * $sin(ang);
               end
               pend_re[k*W +: W] <= 16'($rtoi(ar + (ar >= 0.0 ? 0.5 : -0.5)));
               pend_im[k*W +: W] <= 16'($rtoi(ai + (ai >= 0.0 ? 0.5 : -0.5)));
            end
         end
      end else if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            fft_out_real <= pend_re;
            fft_out_imag <= pend_im;
         end
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (fft_write) wr_cnt++;
      if (fft_start) st_cnt++;
      if (fft_write && fft_start) both_cnt++;
      if (frame_err) ferr_cnt++;
      if (m_valid && !mv_prev && nrise < 8) begin
         rise_cyc[nrise] = cyc;
         nrise++;
      end
      mv_prev = m_valid;
   end

   task automatic send_frame(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         int t;
         logic rdy;
         t = 0;
         s_valid = 1'b1;
         s_real = in_re[i];
         s_imag = in_im[i];
         s_last = with_last && i == n - 1;
         do begin
            rdy = s_ready;
            @(posedge clk);
            #1;
            t++;
         end while (!rdy && t < 100);
         if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout sample %0d: s_ready stayed 0, required 1", i);
         end
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   task automatic drain(input bit rnd, output int got);
      int t;
      logic rdy, stalled;
      logic [W-1:0] p_re, p_im;
      logic [2:0] p_idx;
      got = 0;
      t = 0;
      stalled = 1'b0;
      stab_bad = 0;
      sready_bad = 0;
      p_re = '0;
      p_im = '0;
      p_idx = '0;
      while (got < 8 && t < 300) begin
         rdy = 1'b0;
         if (m_valid) begin
            rdy = rnd ? (t == 0 ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
            obs_re[got] = m_real;
            obs_im[got] = m_imag;
            obs_idx[got] = m_index;
            obs_last[got] = m_last;
            if (stalled && (m_real !== p_re || m_imag !== p_im || m_index !== p_idx)) stab_bad++;
            if (s_ready !== 1'b0) sready_bad++;
            p_re = m_real;
            p_im = m_imag;
            p_idx = m_index;
         end else if (stalled) stab_bad++;
         stalled = m_valid && !rdy;
         m_ready = rdy;
         @(posedge clk);
         #1;
         t++;
         if (rdy) got++;
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({s_ready, m_valid, m_last, fft_write, fft_start, busy, frame_err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 0000000", {s_ready, m_valid, m_last, fft_write, fft_start, busy, frame_err});
      end
      checks++;
      if (m_index !== 3'd0 || m_real !== '0 || m_imag !== '0) begin
         errors++;
         $display("FAIL reset_data idx %0d re %h im %h required 0", m_index, m_real, m_imag);
      end
      checks++;
      if (frames_done !== 16'd0) begin
         errors++;
         $display("FAIL reset_frames got %0d required 0", frames_done);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release s_ready %b busy %b required 1 0", s_ready, busy);
      end
   endtask

   task automatic test_stub_frame();
      int n, got, w0, s0;
      real_mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(k * 256);
         in_im[k] = 16'(-k);
      end
      w0 = wr_cnt;
      s0 = st_cnt;
      send_frame(8, 1'b1);
      checks++;
      if (fft_write !== 1'b1 || fft_start !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stub_write write %b start %b busy %b required 1 0 1", fft_write, fft_start, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (fft_write !== 1'b0 || fft_start !== 1'b1) begin
         errors++;
         $display("FAIL stub_start write %b start %b required 0 1", fft_write, fft_start);
      end
      n = 1;
      while (!m_valid && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != 3 + LAT) begin
         errors++;
         $display("FAIL stub_latency got %0d cycles required %0d", n, 3 + LAT);
      end
      drain(1'b0, got);
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL stub_drain_count got %0d required 8", got);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_re[k] !== 16'(k * 256) || obs_im[k] !== 16'(-k) || obs_idx[k] !== 3'(k) || obs_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL stub_bin%0d got re %h im %h idx %0d last %b required re %h im %h idx %0d last %b",
                     k, obs_re[k], obs_im[k], obs_idx[k], obs_last[k], 16'(k * 256), 16'(-k), k, k == 7);
         end
      end
      checks++;
      if (frames_done !== 16'd1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL stub_done frames %0d s_ready %b m_valid %b required 1 1 0", frames_done, s_ready, m_valid);
      end
      checks++;
      if (wr_cnt - w0 != 1 || st_cnt - s0 != 1 || both_cnt != 0) begin
         errors++;
         $display("FAIL stub_pulses write %0d start %0d overlap %0d required 1 1 0", wr_cnt - w0, st_cnt - s0, both_cnt);
      end
   endtask

   task automatic test_impulse();
      int got, w0, s0;
      real_mode = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = k == 0 ? 16'sd256 : 16'sd0;
         in_im[k] = '0;
      end
      w0 = wr_cnt;
      s0 = st_cnt;
      send_frame(8, 1'b1);
      drain(1'b0, got);
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL impulse_count got %0d required 8", got);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_re[k] !== 16'd256 || obs_im[k] !== 16'd0) begin
            errors++;
            $display("FAIL impulse_bin%0d got re %h im %h required 0100 0000", k, obs_re[k], obs_im[k]);
         end
      end
      checks++;
      if (wr_cnt - w0 != 1 || st_cnt - s0 != 1) begin
         errors++;
         $display("FAIL impulse_pulses write %0d start %0d required 1 1", wr_cnt - w0, st_cnt - s0);
      end
      real_mode = 1'b0;
   endtask

   task automatic test_framing();
      int got, e0;
      e0 = ferr_cnt;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'sd9;
         in_im[k] = 16'sd9;
      end
      send_frame(3, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ferr_cnt - e0 != 1 || busy !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL early_last errs %0d busy %b s_ready %b required 1 0 1", ferr_cnt - e0, busy, s_ready);
      end
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(100 + k);
         in_im[k] = 16'(50 - k);
      end
      send_frame(8, 1'b1);
      drain(1'b0, got);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got != 8 || obs_re[k] !== 16'(100 + k) || obs_im[k] !== 16'(50 - k)) begin
            errors++;
            $display("FAIL restart_bin%0d got re %h im %h required %h %h", k, obs_re[k], obs_im[k], 16'(100 + k), 16'(50 - k));
         end
      end
      checks++;
      if (ferr_cnt - e0 != 1) begin
         errors++;
         $display("FAIL restart_errs got %0d required 1", ferr_cnt - e0);
      end
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(-300 + k * 7);
         in_im[k] = 16'(k * k);
      end
      send_frame(8, 1'b0);
      drain(1'b0, got);
      checks++;
      if (ferr_cnt - e0 != 2) begin
         errors++;
         $display("FAIL missing_last errs %0d required 2", ferr_cnt - e0);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got != 8 || obs_re[k] !== 16'(-300 + k * 7) || obs_im[k] !== 16'(k * k)) begin
            errors++;
            $display("FAIL missing_last_bin%0d got re %h im %h required %h %h", k, obs_re[k], obs_im[k], 16'(-300 + k * 7), 16'(k * k));
         end
      end
   endtask

   task automatic test_backpressure();
      int got;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(1000 * k - 3500);
         in_im[k] = 16'(7 * k + 1);
      end
      send_frame(8, 1'b1);
      drain(1'b1, got);
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL bp_count got %0d required 8", got);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_idx[k] !== 3'(k) || obs_re[k] !== 16'(1000 * k - 3500) || obs_im[k] !== 16'(7 * k + 1) || obs_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL bp_bin%0d got idx %0d re %h im %h last %b required idx %0d re %h im %h last %b",
                     k, obs_idx[k], obs_re[k], obs_im[k], obs_last[k], k, 16'(1000 * k - 3500), 16'(7 * k + 1), k == 7);
         end
      end
      checks++;
      if (stab_bad != 0 || sready_bad != 0) begin
         errors++;
         $display("FAIL bp_stall unstable %0d s_ready_high %0d required 0 0", stab_bad, sready_bad);
      end
   endtask

   task automatic test_back_to_back();
      int f0, e0, w0, t;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(k + 1);
         in_im[k] = 16'(-k - 1);
      end
      f0 = frames_done;
      e0 = ferr_cnt;
      w0 = wr_cnt;
      m_ready = 1'b1;
      nrise = 0;
      repeat (3) send_frame(8, 1'b1);
      t = 0;
      while (frames_done != 16'(f0 + 3) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      m_ready = 1'b0;
      checks++;
      if (frames_done !== 16'(f0 + 3)) begin
         errors++;
         $display("FAIL b2b_frames got %0d required %0d", frames_done, f0 + 3);
      end
      checks++;
      if (nrise != 3 || rise_cyc[1] - rise_cyc[0] != 19 + LAT || rise_cyc[2] - rise_cyc[1] != 19 + LAT) begin
         errors++;
         $display("FAIL b2b_period rises %0d gaps %0d %0d required 3 %0d %0d",
                  nrise, rise_cyc[1] - rise_cyc[0], rise_cyc[2] - rise_cyc[1], 19 + LAT, 19 + LAT);
      end
      checks++;
      if (ferr_cnt != e0 || wr_cnt - w0 != 3) begin
         errors++;
         $display("FAIL b2b_pulses errs %0d writes %0d required 0 3", ferr_cnt - e0, wr_cnt - w0);
      end
   endtask

   task automatic test_reset_wait();
      int got, mv;
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'sd77;
         in_im[k] = 16'sd33;
      end
      send_frame(8, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0 || frames_done !== 16'd0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstwait busy %b m_valid %b frames %0d s_ready %b required 0 0 0 0", busy, m_valid, frames_done, s_ready);
      end
      rst = 1'b1;
      mv = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (m_valid) mv++;
      end
      checks++;
      if (mv != 0) begin
         errors++;
         $display("FAIL rstwait_partial m_valid cycles %0d required 0", mv);
      end
      for (int k = 0; k < 8; k++) begin
         in_re[k] = 16'(1000 + 3 * k);
         in_im[k] = 16'(-500 + k);
      end
      send_frame(8, 1'b1);
      drain(1'b0, got);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (got != 8 || obs_re[k] !== 16'(1000 + 3 * k) || obs_im[k] !== 16'(-500 + k)) begin
            errors++;
            $display("FAIL rstwait_bin%0d got re %h im %h required %h %h", k, obs_re[k], obs_im[k], 16'(1000 + 3 * k), 16'(-500 + k));
         end
      end
      checks++;
      if (frames_done !== 16'd1) begin
         errors++;
         $display("FAIL rstwait_frames got %0d required 1", frames_done);
      end
   endtask

   initial begin
      test_reset();
      test_stub_frame();
      test_impulse();
      test_framing();
      test_backpressure();
      test_back_to_back();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
